// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Addresses with any bit set at or above this position fall outside the Memory.
  localparam int unsigned MEM_ADDR_LSBS = 10;

  localparam int unsigned AW_DEF         = 32;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef struct packed {
    logic port;
    logic we;
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshakes plus Memory pins shared by the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          addr_err;

  logic          m_ren;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout,
    output i_ack, i_rdata, d_ack, d_rdata, addr_err, m_ren, m_wen, m_addr, m_din
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout,
    input  i_ack, i_rdata, d_ack, d_rdata, addr_err, m_ren, m_wen, m_addr, m_din
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select (D priority) with a saturating guard that forces an I grant
// after STARVE_MAX consecutive D grants taken while I was waiting.
module mem_arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic decide,
  output logic grant_d_c
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          starved_c;

  assign starved_c = (cnt_q == CW'(STARVE_MAX));

  always_comb begin
    grant_d_c = d_req && !(i_req && starved_c);
  end

  // Count only at decision edges; any I grant or an idle I port clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (decide) begin
      if (grant_d_c && i_req) begin
        cnt_d = starved_c ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word Memory between the instruction-fetch and
// load/store ports: IDLE decides, ACCESS drives the Memory, RESP acknowledges.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic             clock,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  logic [1:0]    state_q, state_d;
  grant_t        lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          decide_c;
  logic          grant_d_c;

  assign decide_c = (state_q == ST_IDLE) && (bus.i_req || bus.d_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clock     (clock),
    .reset     (reset),
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .decide    (decide_c),
    .grant_d_c (grant_d_c)
  );

  // Next state and next register values; strobes default low so they pulse.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    din_d     = din_q;
    ren_d     = 1'b0;
    wen_d     = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (decide_c) begin
          if (grant_d_c) begin
            lat_d  = '{port: PORT_D, we: bus.d_we};
            addr_d = bus.d_addr;
            din_d  = bus.d_wdata;
          end else begin
            lat_d  = '{port: PORT_I, we: 1'b0};
            addr_d = bus.i_addr;
          end
          ren_d   = ~lat_d.we;
          wen_d   = lat_d.we;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!lat_q.we) begin
          if (lat_q.port == PORT_D) begin
            d_rdata_d = bus.m_dout;
          end else begin
            i_rdata_d = bus.m_dout;
          end
        end
        if (lat_q.port == PORT_D) begin
          d_ack_d = 1'b1;
        end else begin
          i_ack_d = 1'b1;
        end
        err_d   = |addr_q[AW-1:MEM_ADDR_LSBS];
        state_d = ST_RESP;
      end

      // Requests are not sampled here so the requester can drop or renew.
      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_ren    = ren_q;
  assign bus.m_wen    = wen_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_din    = din_q;
  assign bus.i_ack    = i_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.addr_err = err_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
